// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen: synchronises the VGA frame clock into Clk and derives NUM_CH independently divided game ticks.
// Optional: define TICK_STAGGER_EN to preload counter i with i mod DIV_RESET at reset so equal-rate channels never tick together.
module multi_rate_tick_gen #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 4,
  parameter int DIV_RESET = 4,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              pause,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic              frame_edge,
  output logic [NUM_CH-1:0] tick
);

`ifdef TICK_STAGGER_EN
  localparam int STAGGER = 1;
`else
  localparam int STAGGER = 0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              s1_r;
  logic              s2_r;
  logic              s3_r;
  logic              frame_edge_r;
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] wr_hit_s;
  logic              count_s;
  logic [CNT_W-1:0]  cnt_r [NUM_CH];
  logic [CNT_W-1:0]  cnt_s [NUM_CH];
  logic [CNT_W-1:0]  div_r [NUM_CH];
  logic [CNT_W-1:0]  div_s [NUM_CH];

  function automatic logic [CNT_W-1:0] reset_cnt(input int ch);
    reset_cnt = CNT_W'((ch % DIV_RESET) * STAGGER);
  endfunction

  // A stored divisor of 0 behaves as 1, so its terminal count is 0 as well.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] div);
    last_cnt = (div == CNT_ZERO) ? CNT_ZERO : div - CNT_ONE;
  endfunction

  // Three-flop synchroniser for the asynchronous frame clock plus rising-edge pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      s3_r         <= 1'b0;
      frame_edge_r <= 1'b0;
    end else begin
      s1_r         <= frame_clk;
      s2_r         <= s1_r;
      s3_r         <= s2_r;
      frame_edge_r <= s2_r & ~s3_r;
    end
  end

  // Channel next state: a divisor write beats disable, which beats counting
  always_comb begin
    count_s = frame_edge_r & ~pause;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i] = div_we && (div_sel == SEL_W'(i));
      div_s[i]    = div_r[i];
      cnt_s[i]    = cnt_r[i];
      tick_s[i]   = 1'b0;
      if (wr_hit_s[i]) begin
        div_s[i] = div_val;
        cnt_s[i] = CNT_ZERO;
      end else if (!ch_en[i]) begin
        cnt_s[i] = CNT_ZERO;
      end else if (count_s) begin
        // >= rather than == so a divisor lowered below the count wraps at once
        if (cnt_r[i] >= last_cnt(div_r[i])) begin
          cnt_s[i]  = CNT_ZERO;
          tick_s[i] = 1'b1;
        end else begin
          cnt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_s[i] = cnt_r[i];
      end
    end
  end

  // Channel state and tick output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= reset_cnt(i);
        div_r[i] <= CNT_W'(DIV_RESET);
      end
    end else begin
      tick_r <= tick_s;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_s[i];
        div_r[i] <= div_s[i];
      end
    end
  end

  assign frame_edge = frame_edge_r;
  assign tick       = tick_r;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Self-checking bench for multi_rate_tick_gen: an edge-counting reference model is compared every Clk,
// plus directed frame scenarios with hand-computed tick counts.
module tb_multi_rate_tick_gen;
  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 4;
  localparam int DIV_RESET = 4;
  localparam int SEL_W     = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              frame_clk;
  logic              pause;
  logic [NUM_CH-1:0] ch_en;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic              frame_edge;
  logic [NUM_CH-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;

  multi_rate_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RESET(DIV_RESET)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pause(pause), .ch_en(ch_en),
    .div_we(div_we), .div_sel(div_sel), .div_val(div_val),
    .frame_edge(frame_edge), .tick(tick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame_clk history in posedge samples, per-channel edges seen since last restart
  int            div_m  [NUM_CH];
  int            seen_m [NUM_CH];
  bit            hist [4];
  bit            edge_m;
  bit [NUM_CH-1:0] tick_m;
  int            cyc = 0;
  int            edge_cnt = 0;
  int            tick_cnt [NUM_CH];
  int            first_high_cyc = -1;
  int            first_tick0_cyc = -1;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      div_m[i] = DIV_RESET;
`ifdef TICK_STAGGER_EN
      seen_m[i] = i % DIV_RESET;
`else
      seen_m[i] = 0;
`endif
    end
    for (int j = 0; j < 4; j++) hist[j] = 1'b0;
    edge_m = 1'b0;
    tick_m = '0;
  endtask

  initial begin : compare
    int eff;
    for (int i = 0; i < NUM_CH; i++) tick_cnt[i] = 0;
    model_reset();
    forever begin
      @(posedge Clk);
      cyc++;
      if (Reset) begin
        model_reset();
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          tick_m[i] = 1'b0;
          if (div_we && int'(div_sel) == i) begin
            div_m[i]  = int'(div_val);
            seen_m[i] = 0;
          end else if (!ch_en[i]) begin
            seen_m[i] = 0;
          end else if (edge_m && !pause) begin
            eff = (div_m[i] == 0) ? 1 : div_m[i];
            if (seen_m[i] + 1 >= eff) begin
              tick_m[i] = 1'b1;
              seen_m[i] = 0;
            end else begin
              seen_m[i]++;
            end
          end
        end
        for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = frame_clk;
        edge_m  = hist[2] & ~hist[3];
        if (frame_clk && first_high_cyc < 0) first_high_cyc = cyc;
      end
      #1;
      check("frame_edge", {31'b0, frame_edge}, {31'b0, edge_m});
      check("tick", {28'b0, tick}, {28'b0, tick_m});
      if (frame_edge === 1'b1) edge_cnt++;
      for (int i = 0; i < NUM_CH; i++) if (tick[i] === 1'b1) tick_cnt[i]++;
      if (tick[0] === 1'b1 && first_tick0_cyc < 0) first_tick0_cyc = cyc;
    end
  end

  task automatic frame(input int hi, input int lo);
    frame_clk = 1'b1;
    repeat (hi) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (lo) @(negedge Clk);
  endtask

  task automatic wr(input int sel, input int val);
    div_sel = SEL_W'(sel);
    div_val = CNT_W'(val);
    div_we  = 1'b1;
    @(negedge Clk);
    div_we  = 1'b0;
  endtask

  // One frame with a divisor write landing on the same Clk as the frame_edge pulse
  task automatic frame_wr(input int sel, input int val, output bit hit);
    hit = 1'b0;
    frame_clk = 1'b1;
    div_sel = SEL_W'(sel);
    div_val = CNT_W'(val);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) frame_clk = 1'b0;
      if (!hit && frame_edge === 1'b1) begin
        div_we = 1'b1;
        hit    = 1'b1;
      end else begin
        div_we = 1'b0;
      end
      @(negedge Clk);
    end
    div_we = 1'b0;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int snap [NUM_CH];
    int snap_e;
    int sum;
    bit hit;
    Reset = 1'b1; frame_clk = 1'b0; pause = 1'b0; div_we = 1'b0;
    ch_en = '1; div_sel = '0; div_val = '0;
    repeat (3) @(negedge Clk);
    check("reset_frame_edge", {31'b0, frame_edge}, 32'd0);
    check("reset_tick", {28'b0, tick}, 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // 12 frames at the reset divisor of 4: three ticks per channel
    snap_e = edge_cnt;
    for (int i = 0; i < NUM_CH; i++) snap[i] = tick_cnt[i];
    repeat (12) frame(4, 4);
    repeat (4) @(negedge Clk);
    check("a_edges", edge_cnt - snap_e, 32'd12);
    for (int i = 0; i < NUM_CH; i++) check($sformatf("a_ticks_ch%0d", i), tick_cnt[i] - snap[i], 32'd3);
    // edges at k+2, k+10, k+18, k+26; fourth edge counted at posedge k+27
    check("a_first_tick_latency", first_tick0_cyc - first_high_cyc, 32'd27);

    // divisors 1 and 0 both tick every edge; ch0 keeps 1-in-4
    wr(1, 1);
    wr(2, 0);
    for (int i = 0; i < NUM_CH; i++) snap[i] = tick_cnt[i];
    repeat (5) frame(4, 4);
    check("b_ch1", tick_cnt[1] - snap[1], 32'd5);
    check("b_ch2", tick_cnt[2] - snap[2], 32'd5);
    check("b_ch0", tick_cnt[0] - snap[0], 32'd1);

    // pause over four frames after two counted ones
    wr(0, 4);
    repeat (2) frame(4, 4);
    pause = 1'b1;
    snap_e = edge_cnt;
    for (int i = 0; i < NUM_CH; i++) snap[i] = tick_cnt[i];
    repeat (4) frame(4, 4);
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) sum += tick_cnt[i] - snap[i];
    check("c_paused_edges", edge_cnt - snap_e, 32'd4);
    check("c_paused_ticks", sum, 32'd0);
    pause = 1'b0;
    snap[0] = tick_cnt[0];
    frame(4, 4);
    check("c_resume_1", tick_cnt[0] - snap[0], 32'd0);
    frame(4, 4);
    check("c_resume_2", tick_cnt[0] - snap[0], 32'd1);

    // divisor write coinciding with frame_edge: write wins, then 3 edges to next tick
    snap[0] = tick_cnt[0];
    frame_wr(0, 3, hit);
    check("d_write_on_edge_seen", {31'b0, hit}, 32'd1);
    check("d_no_tick_on_write", tick_cnt[0] - snap[0], 32'd0);
    repeat (2) frame(4, 4);
    check("d_after_2", tick_cnt[0] - snap[0], 32'd0);
    frame(4, 4);
    check("d_after_3", tick_cnt[0] - snap[0], 32'd1);

    // channel 3 disabled then re-enabled: restart from zero
    ch_en[3] = 1'b0;
    snap[3] = tick_cnt[3];
    repeat (3) frame(4, 4);
    check("e_disabled", tick_cnt[3] - snap[3], 32'd0);
    ch_en[3] = 1'b1;
    snap[3] = tick_cnt[3];
    repeat (3) frame(4, 4);
    check("e_reen_3", tick_cnt[3] - snap[3], 32'd0);
    frame(4, 4);
    check("e_reen_4", tick_cnt[3] - snap[3], 32'd1);

    // randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) ch_en = ch_en ^ (NUM_CH'(1) << $urandom_range(0, NUM_CH-1));
      div_we  = ($urandom_range(0, 14) == 0);
      div_sel = SEL_W'($urandom_range(0, NUM_CH-1));
      div_val = ($urandom_range(0, 1) == 1) ? CNT_W'($urandom_range(0, 3)) : CNT_W'($urandom_range(0, 15));
      @(negedge Clk);
    end
    div_we = 1'b0; pause = 1'b0; ch_en = '1; frame_clk = 1'b0;
    repeat (6) @(negedge Clk);

    // reset mid-count while a tick is high
    wr(1, 1);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    check("f_pre_reset_tick1", {31'b0, tick[1]}, 32'd1);
    Reset = 1'b1;
    #1;
    check("f_reset_tick", {28'b0, tick}, 32'd0);
    check("f_reset_edge", {31'b0, frame_edge}, 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    for (int i = 0; i < NUM_CH; i++) snap[i] = tick_cnt[i];
    repeat (4) frame(4, 4);
    for (int i = 0; i < NUM_CH; i++) check($sformatf("f_post_reset_ch%0d", i), tick_cnt[i] - snap[i], 32'd1);

    repeat (4) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
